uart_tx_wb: RTL and testbench

//  Wishbone-slave UART transmitter in the user project area: firmware writes bytes, block serialises 8N1 onto an mprj_io pin.

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 61 ++++++
 rtl/uart_tx_wb.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_wb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map,
// STATUS bit positions and the serialiser state encoding.
package uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CLKDIV = 2'd2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through output.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned AW = $clog2(FIFO_DEPTH),
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    output logic [7:0]    dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_wb.sv
// Wishbone-slave 8N1 UART transmitter: register decode, CLKDIV/OVF state,
// byte FIFO and a registered-output serialiser FSM.
module uart_tx_wb
    import uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd347
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tx_o,
    output logic        tx_oeb,
    output logic        irq_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          ack_q;
    logic [31:0]   dat_q;
    logic          oeb_q;
    logic          irq_q;
    logic [15:0]   clkdiv_q;
    logic          ovf_q;

    tx_state_t     state_q;
    logic          tx_q;
    logic [15:0]   cnt_q;
    logic [15:0]   div_q;
    logic [7:0]    sh_q;
    logic [2:0]    idx_q;

    logic          req;
    logic          wr_req;
    logic          rd_req;
    logic [1:0]    addr;
    logic          push_req;
    logic          busy;
    logic          bit_end;
    logic          pop;
    logic [31:0]   rdata;

    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          unused_ok;
    assign unused_ok = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0],
                         wbs_dat_i[31:16], wbs_sel_i[3:2]};

    assign req      = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr_req   = req & wbs_we_i;
    assign rd_req   = req & ~wbs_we_i;
    assign addr     = wbs_adr_i[3:2];
    assign push_req = wr_req & (addr == REG_TXDATA) & wbs_sel_i[0];

    assign busy    = (state_q != IDLE);
    assign bit_end = (cnt_q == div_q);
    assign pop     = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign tx_o      = tx_q;
    assign tx_oeb    = oeb_q;
    assign irq_o     = irq_q;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n),
        .push_i  (push_req),
        .din_i   (wbs_dat_i[7:0]),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        rdata = '0;
        case (addr)
            REG_STATUS: begin
                rdata[STAT_BUSY]                   = busy;
                rdata[STAT_FULL]                   = fifo_full;
                rdata[STAT_EMPTY]                  = fifo_empty;
                rdata[STAT_OVF]                    = ovf_q;
                rdata[STAT_CNT_LSB +: 8]           = 8'(fifo_count);
            end
            REG_CLKDIV: rdata[15:0] = clkdiv_q;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            oeb_q    <= 1'b1;
            irq_q    <= 1'b0;
            clkdiv_q <= DEFAULT_DIV;
            ovf_q    <= 1'b0;
        end else begin
            ack_q <= req;
            dat_q <= rd_req ? rdata : '0;
            oeb_q <= 1'b0;
            irq_q <= fifo_empty & ~busy;
            if (wr_req) begin
                case (addr)
                    REG_STATUS: begin
                        if (wbs_sel_i[0] && wbs_dat_i[STAT_OVF]) begin
                            ovf_q <= 1'b0;
                        end
                    end
                    REG_CLKDIV: begin
                        if (wbs_sel_i[0]) clkdiv_q[7:0]  <= wbs_dat_i[7:0];
                        if (wbs_sel_i[1]) clkdiv_q[15:8] <= wbs_dat_i[15:8];
                    end
                    default: ;
                endcase
            end
            // Full is sampled before any same-cycle pop, so a push at full always drops.
            if (push_req && fifo_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            div_q   <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= START;
                        tx_q    <= 1'b0;
                        sh_q    <= fifo_dout;
                        div_q   <= clkdiv_q;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= sh_q[0];
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            sh_q  <= {1'b0, sh_q[7:1]};
                            tx_q  <= sh_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (!fifo_empty) begin
                            state_q <= START;
                            tx_q    <= 1'b0;
                            sh_q    <= fifo_dout;
                            div_q   <= clkdiv_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_wb.sv
// Directed and randomized checks of uart_tx_wb against a frame-level line model.
`define CHK(TAG, OBS, EXP) begin n_checks++; assert ((OBS) === (EXP)) else begin n_errors++; $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); end end

module tb_uart_tx_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        tx, oeb, irq;

    int n_checks = 0;
    int n_errors = 0;

    bit           rec = 1'b0;
    logic         line_q[$];
    byte unsigned fb[$];
    int           fd[$];

    always #5 clk = ~clk;

    uart_tx_wb #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd347)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .tx_o      (tx),
        .tx_oeb    (oeb),
        .irq_o     (irq)
    );

    always @(negedge clk) if (rec) line_q.push_back(tx);

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wb_acc(input logic w, input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; wdat = d;
        adr = {$urandom_range(0, 15) == 0 ? 28'h3000000 : 28'h0, a, 2'b00};
        @(posedge clk); #1;
        `CHK("ack_hi", ack, 1'b1)
        rd  = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        `CHK("ack_lo", ack, 1'b0)
        `CHK("dat_idle", rdat, 32'h0)
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_acc(1'b1, a, d, s, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_acc(1'b0, a, 32'h0, 4'hF, v);
        `CHK(tag, v, exp)
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (irq !== 1'b1 && k < maxc) begin
            @(posedge clk); #1;
            k++;
        end
        `CHK("idle_timeout", irq, 1'b1)
    endtask

    // Model: each queued byte is a 10-level frame (start, 8 data LSB first, stop),
    // every level lasting div+1 clocks; the line is high everywhere else.
    task automatic check_frames(input string tag, input bit allow_gap);
        int pos = 0;
        int mism = 0;
        repeat (4) @(negedge clk);
        #1 rec = 1'b0;
        for (int f = 0; f < fb.size(); f++) begin
            byte unsigned cur = fb[f];
            if (f == 0 || allow_gap)
                while (pos < line_q.size() && line_q[pos] === 1'b1) pos++;
            for (int b = 0; b < 10; b++) begin
                logic lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
                for (int c = 0; c <= fd[f]; c++) begin
                    if (pos >= line_q.size() || line_q[pos] !== lvl) mism++;
                    pos++;
                end
            end
        end
        while (pos < line_q.size()) begin
            if (line_q[pos] !== 1'b1) mism++;
            pos++;
        end
        `CHK(tag, mism, 0)
        line_q.delete();
        fb.delete();
        fd.delete();
    endtask

    initial begin
        logic [31:0] exp_st;
        int k;
        int first;
        byte unsigned b;
        byte unsigned pend[$];
        bit ovf_m;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
        #12;
        `CHK("rst_tx", tx, 1'b1)
        `CHK("rst_oeb", oeb, 1'b1)
        `CHK("rst_ack", ack, 1'b0)
        `CHK("rst_dat", rdat, 32'h0)
        `CHK("rst_irq", irq, 1'b0)
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        `CHK("oeb_run", oeb, 1'b0)
        rd_chk("status_rst", 2'd1, 32'h4);
        rd_chk("clkdiv_rst", 2'd2, 32'd347);
        `CHK("tx_idle", tx, 1'b1)

        // Register map corners.
        rd_chk("txdata_rd", 2'd0, 32'h0);
        wr(2'd3, 32'hFFFF_FFFF, 4'hF);
        rd_chk("reserved_rd", 2'd3, 32'h0);
        wr(2'd2, 32'h0000_0003, 4'h3);
        wr(2'd2, 32'h1234_ABCD, 4'h2);
        rd_chk("clkdiv_lane", 2'd2, 32'h0000_AB03);
        wr(2'd2, 32'h0000_0003, 4'h3);
        wr(2'd0, 32'h0000_0055, 4'hE);
        rd_chk("sel0_nopush", 2'd1, 32'h4);

        // Single 0xA5 frame at 4-cycle bits.
        rec = 1'b1;
        fb.push_back(8'hA5); fd.push_back(3);
        wr(2'd0, 32'h0000_00A5, 4'h1);
        `CHK("irq_busy", irq, 1'b0)
        rd_chk("status_busy", 2'd1, 32'h5);
        wait_idle(200);
        rd_chk("status_done", 2'd1, 32'h4);
        check_frames("frame_a5", 1'b0);

        // Back-to-back frames must abut with no idle gap.
        rec = 1'b1;
        fb.push_back(8'h00); fd.push_back(3);
        fb.push_back(8'hFF); fd.push_back(3);
        wr(2'd0, 32'h0000_0000, 4'h1);
        wr(2'd0, 32'h0000_00FF, 4'h1);
        wait_idle(300);
        check_frames("frame_b2b", 1'b0);

        // Randomized dividers (including 0) and byte bursts.
        for (int it = 0; it < 4; it++) begin
            int dv = $urandom_range(0, 4);
            int nb = $urandom_range(1, 3);
            wr(2'd2, dv, 4'h3);
            rec = 1'b1;
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom);
                fb.push_back(b); fd.push_back(dv);
                wr(2'd0, {24'h0, b}, 4'h1);
            end
            wait_idle(400);
            check_frames("frame_rand", 1'b1);
        end

        // Overflow: first byte goes straight to the shifter, next eight fill the FIFO.
        wr(2'd2, 32'd100, 4'h3);
        rec = 1'b1;
        ovf_m = 1'b0;
        for (int j = 0; j < 10; j++) begin
            b = 8'($urandom);
            if (j == 0) begin
                fb.push_back(b); fd.push_back(100);
            end else if (pend.size() < 8) begin
                pend.push_back(b); fb.push_back(b); fd.push_back(100);
            end else begin
                ovf_m = 1'b1;
            end
            wr(2'd0, {24'h0, b}, 4'h1);
        end
        exp_st = {16'h0, 8'(pend.size()), 4'h0, ovf_m, 1'b0, (pend.size() == 8), 1'b1};
        rd_chk("status_ovf", 2'd1, exp_st);
        wr(2'd1, 32'h0000_0008, 4'h1);
        exp_st[3] = 1'b0;
        rd_chk("ovf_clear", 2'd1, exp_st);
        wait_idle(12000);
        rd_chk("status_drain", 2'd1, 32'h4);
        check_frames("frame_ovf", 1'b0);
        pend.delete();

        // CLKDIV change mid-frame applies to the following frame only.
        wr(2'd2, 32'd3, 4'h3);
        rec = 1'b1;
        fb.push_back(8'h3C); fd.push_back(3);
        wr(2'd0, 32'h0000_003C, 4'h1);
        wr(2'd2, 32'd7, 4'h3);
        fb.push_back(8'hC3); fd.push_back(7);
        wr(2'd0, 32'h0000_00C3, 4'h1);
        wait_idle(400);
        check_frames("frame_divchg", 1'b0);
        rd_chk("clkdiv_7", 2'd2, 32'd7);

        // Reset during data bit 4 with bytes still queued.
        wr(2'd2, 32'd3, 4'h3);
        rec = 1'b1;
        b = 8'($urandom) & 8'hEF;
        wr(2'd0, {24'h0, b}, 4'h1);
        wr(2'd0, 32'h0000_0011, 4'h1);
        wr(2'd0, 32'h0000_0022, 4'h1);
        first = -1;
        k = 0;
        while (first < 0 && k < 100) begin
            for (int i = 0; i < line_q.size(); i++)
                if (first < 0 && line_q[i] === 1'b0) first = i;
            if (first < 0) begin @(negedge clk); #1; end
            k++;
        end
        `CHK("start_seen", (first >= 0), 1'b1)
        k = 0;
        while (line_q.size() < first + 22 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        `CHK("bit4_low", tx, 1'b0)
        rst_n = 1'b0;
        #1;
        `CHK("rst_async_tx", tx, 1'b1)
        `CHK("rst_async_oeb", oeb, 1'b1)
        rec = 1'b0;
        line_q.delete();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        rd_chk("status_post_rst", 2'd1, 32'h4);
        rd_chk("clkdiv_post_rst", 2'd2, 32'd347);
        rec = 1'b1;
        repeat (60) @(negedge clk);
        check_frames("no_residual", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
